ita_requant_const_loader: RTL and testbench

- Writer side of the requantization constant set: accepts a valid/ready stream of constant writes, stages them in a shadow bank, and on a commit request copies the whole bank to the active outputs once the engine is idle.
- The active outputs feed the controller's per-step and activation requantization constant fields, so in-flight computation never sees a partially updated set.
- Sits between the host/config front-end and the requantization path.

---
 rtl/ita_requant_const_loader.sv | 161 ++++++++++++++++
 tb/tb_ita_requant_const_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ita_requant_const_loader.sv
// Requantization constant loader: host writes land in a shadow bank and are copied to the active bank once the engine is idle.
// Define ITA_REQUANT_READBACK_EN to add a registered shadow-bank read port.
module ita_requant_const_loader #(
  parameter  int NumConsts = 6,
  parameter  int ConstW    = 8,
  localparam int IdxW      = $clog2(NumConsts + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              wr_valid_i,
  output logic                              wr_ready_o,
  input  logic [IdxW-1:0]                   wr_idx_i,
  input  logic [ConstW-1:0]                 wr_mult_i,
  input  logic [ConstW-1:0]                 wr_shift_i,
  input  logic signed [ConstW-1:0]          wr_add_i,
  input  logic                              commit_i,
  input  logic                              busy_i,
  output logic                              commit_done_o,
  output logic                              idx_err_o,
  output logic [NumConsts-1:0][ConstW-1:0]  eps_mult_o,
  output logic [NumConsts-1:0][ConstW-1:0]  right_shift_o,
  output logic [NumConsts-1:0][ConstW-1:0]  add_o,
  output logic [ConstW-1:0]                 act_mult_o,
  output logic [ConstW-1:0]                 act_shift_o,
  output logic signed [ConstW-1:0]          act_add_o
`ifdef ITA_REQUANT_READBACK_EN
  ,
  input  logic                              rd_en_i,
  input  logic [IdxW-1:0]                   rd_idx_i,
  output logic [ConstW-1:0]                 rd_mult_o,
  output logic [ConstW-1:0]                 rd_shift_o,
  output logic signed [ConstW-1:0]          rd_add_o
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_IDLE, COPY} state_e;

  localparam int                NumSlots = NumConsts + 1;
  localparam logic [IdxW-1:0]   ActIdx   = IdxW'(NumConsts);
  localparam logic [ConstW-1:0] MultRst  = ConstW'(1);

  state_e r_state, w_state_nxt;

  logic [ConstW-1:0]        r_sh_mult  [NumSlots];
  logic [ConstW-1:0]        r_sh_shift [NumSlots];
  logic signed [ConstW-1:0] r_sh_add   [NumSlots];

  logic [NumConsts-1:0][ConstW-1:0] r_eps_mult, r_right_shift, r_add;
  logic [ConstW-1:0]                r_act_mult, r_act_shift;
  logic signed [ConstW-1:0]         r_act_add;
  logic                             r_commit_done, r_idx_err;

  logic w_wr_hs, w_idx_ok, w_copy;

  assign wr_ready_o = (r_state == IDLE);
  assign w_wr_hs    = wr_valid_i & wr_ready_o;
  assign w_idx_ok   = (wr_idx_i <= ActIdx);
  assign w_copy     = (r_state == COPY);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // A commit raised outside IDLE is simply not looked at.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (commit_i) w_state_nxt = WAIT_IDLE;
      WAIT_IDLE: if (!busy_i)  w_state_nxt = COPY;
      COPY:      w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSlots; i++) begin
        r_sh_mult[i]  <= MultRst;
        r_sh_shift[i] <= '0;
        r_sh_add[i]   <= '0;
      end
    end else if (w_wr_hs && w_idx_ok) begin
      r_sh_mult[wr_idx_i]  <= wr_mult_i;
      r_sh_shift[wr_idx_i] <= wr_shift_i;
      r_sh_add[wr_idx_i]   <= wr_add_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumConsts; i++) begin
        r_eps_mult[i]    <= MultRst;
        r_right_shift[i] <= '0;
        r_add[i]         <= '0;
      end
      r_act_mult  <= MultRst;
      r_act_shift <= '0;
      r_act_add   <= '0;
    end else if (w_copy) begin
      for (int i = 0; i < NumConsts; i++) begin
        r_eps_mult[i]    <= r_sh_mult[i];
        r_right_shift[i] <= r_sh_shift[i];
        r_add[i]         <= r_sh_add[i];
      end
      r_act_mult  <= r_sh_mult[NumConsts];
      r_act_shift <= r_sh_shift[NumConsts];
      r_act_add   <= r_sh_add[NumConsts];
    end
  end

  // The error flag drops together with the rising commit_done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_commit_done <= 1'b0;
      r_idx_err     <= 1'b0;
    end else begin
      r_commit_done <= w_copy;
      if (w_copy)                     r_idx_err <= 1'b0;
      else if (w_wr_hs && !w_idx_ok)  r_idx_err <= 1'b1;
    end
  end

  assign commit_done_o = r_commit_done;
  assign idx_err_o     = r_idx_err;
  assign eps_mult_o    = r_eps_mult;
  assign right_shift_o = r_right_shift;
  assign add_o         = r_add;
  assign act_mult_o    = r_act_mult;
  assign act_shift_o   = r_act_shift;
  assign act_add_o     = r_act_add;

`ifdef ITA_REQUANT_READBACK_EN
  logic [ConstW-1:0]        r_rd_mult, r_rd_shift;
  logic signed [ConstW-1:0] r_rd_add;

  // Reads sample the shadow bank before any same-edge write lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_mult  <= '0;
      r_rd_shift <= '0;
      r_rd_add   <= '0;
    end else if (rd_en_i) begin
      if (rd_idx_i <= ActIdx) begin
        r_rd_mult  <= r_sh_mult[rd_idx_i];
        r_rd_shift <= r_sh_shift[rd_idx_i];
        r_rd_add   <= r_sh_add[rd_idx_i];
      end else begin
        r_rd_mult  <= '0;
        r_rd_shift <= '0;
        r_rd_add   <= '0;
      end
    end
  end

  assign rd_mult_o  = r_rd_mult;
  assign rd_shift_o = r_rd_shift;
  assign rd_add_o   = r_rd_add;
`endif

endmodule

// File: tb/tb_ita_requant_const_loader.sv
// Bench for ita_requant_const_loader: directed stimulus, behavioural model compared every cycle, plus literal spot checks.
module tb_ita_requant_const_loader;
  localparam int N  = 6;
  localparam int W  = 8;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b1;
  logic           wr_valid_i, wr_ready_o;
  logic [IW-1:0]  wr_idx_i;
  logic [W-1:0]   wr_mult_i, wr_shift_i, wr_add_i;
  logic           commit_i, busy_i, commit_done_o, idx_err_o;
  logic [N-1:0][W-1:0] eps_mult_o, right_shift_o, add_o;
  logic [W-1:0]   act_mult_o, act_shift_o, act_add_o;
`ifdef ITA_REQUANT_READBACK_EN
  logic           rd_en_i;
  logic [IW-1:0]  rd_idx_i;
  logic [W-1:0]   rd_mult_o, rd_shift_o, rd_add_o;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  ita_requant_const_loader #(.NumConsts(N), .ConstW(W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_idx_i(wr_idx_i),
    .wr_mult_i(wr_mult_i), .wr_shift_i(wr_shift_i), .wr_add_i(wr_add_i),
    .commit_i(commit_i), .busy_i(busy_i), .commit_done_o(commit_done_o),
    .idx_err_o(idx_err_o), .eps_mult_o(eps_mult_o), .right_shift_o(right_shift_o),
    .add_o(add_o), .act_mult_o(act_mult_o), .act_shift_o(act_shift_o),
    .act_add_o(act_add_o)
`ifdef ITA_REQUANT_READBACK_EN
    , .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i), .rd_mult_o(rd_mult_o),
    .rd_shift_o(rd_shift_o), .rd_add_o(rd_add_o)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: slot arrays (index N = activation), a pending-commit flag and a copy-on-next-edge flag.
  logic [W-1:0] m_sh_mult[N+1], m_sh_shift[N+1], m_sh_add[N+1];
  logic [W-1:0] m_ac_mult[N+1], m_ac_shift[N+1], m_ac_add[N+1];
  logic         m_pending, m_copy_now, m_done, m_err;
`ifdef ITA_REQUANT_READBACK_EN
  logic [W-1:0] m_rd_mult, m_rd_shift, m_rd_add;
`endif

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i <= N; i++) begin
        m_sh_mult[i] <= 8'd1; m_sh_shift[i] <= 8'd0; m_sh_add[i] <= 8'd0;
        m_ac_mult[i] <= 8'd1; m_ac_shift[i] <= 8'd0; m_ac_add[i] <= 8'd0;
      end
      m_pending <= 1'b0; m_copy_now <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
`ifdef ITA_REQUANT_READBACK_EN
      m_rd_mult <= 8'd0; m_rd_shift <= 8'd0; m_rd_add <= 8'd0;
`endif
    end else begin
      m_done <= 1'b0;
      if (m_copy_now) begin
        for (int i = 0; i <= N; i++) begin
          m_ac_mult[i] <= m_sh_mult[i]; m_ac_shift[i] <= m_sh_shift[i]; m_ac_add[i] <= m_sh_add[i];
        end
        m_done <= 1'b1; m_err <= 1'b0; m_copy_now <= 1'b0; m_pending <= 1'b0;
      end else if (m_pending) begin
        if (!busy_i) m_copy_now <= 1'b1;
      end else begin
        if (wr_valid_i) begin
          if (int'(wr_idx_i) <= N) begin
            m_sh_mult[wr_idx_i] <= wr_mult_i;
            m_sh_shift[wr_idx_i] <= wr_shift_i;
            m_sh_add[wr_idx_i] <= wr_add_i;
          end else begin
            m_err <= 1'b1;
          end
        end
        if (commit_i) m_pending <= 1'b1;
      end
`ifdef ITA_REQUANT_READBACK_EN
      if (rd_en_i) begin
        if (int'(rd_idx_i) <= N) begin
          m_rd_mult <= m_sh_mult[rd_idx_i]; m_rd_shift <= m_sh_shift[rd_idx_i]; m_rd_add <= m_sh_add[rd_idx_i];
        end else begin
          m_rd_mult <= 8'd0; m_rd_shift <= 8'd0; m_rd_add <= 8'd0;
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (commit_done_o === 1'b1) done_cnt <= done_cnt + 1;
    chk("ready", wr_ready_o, !m_pending);
    chk("commit_done", commit_done_o, m_done);
    chk("idx_err", idx_err_o, m_err);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("eps_mult[%0d]", i), eps_mult_o[i], m_ac_mult[i]);
      chk($sformatf("right_shift[%0d]", i), right_shift_o[i], m_ac_shift[i]);
      chk($sformatf("add[%0d]", i), add_o[i], m_ac_add[i]);
    end
    chk("act_mult", act_mult_o, m_ac_mult[N]);
    chk("act_shift", act_shift_o, m_ac_shift[N]);
    chk("act_add", act_add_o, m_ac_add[N]);
`ifdef ITA_REQUANT_READBACK_EN
    chk("rd_mult", rd_mult_o, m_rd_mult);
    chk("rd_shift", rd_shift_o, m_rd_shift);
    chk("rd_add", rd_add_o, m_rd_add);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input int m, input int s, input int a);
    wr_valid_i = 1'b1;
    wr_idx_i   = IW'(idx);
    wr_mult_i  = W'(m);
    wr_shift_i = W'(s);
    wr_add_i   = W'(a);
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic commit_pulse();
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    wr_valid_i = 1'b0; wr_idx_i = '0; wr_mult_i = '0; wr_shift_i = '0; wr_add_i = '0;
    commit_i = 1'b0; busy_i = 1'b0;
`ifdef ITA_REQUANT_READBACK_EN
    rd_en_i = 1'b0; rd_idx_i = '0;
`endif
    #1 rst_ni = 1'b0;
    tick(); tick();
    chk("rst_ready", wr_ready_o, 1);
    chk("rst_eps_mult0", eps_mult_o[0], 8'd1);
    chk("rst_act_mult", act_mult_o, 8'd1);
    chk("rst_act_add", act_add_o, 8'd0);
    chk("rst_done", commit_done_o, 0);
    rst_ni = 1'b1;
    tick();

    // Basic load with idle engine: new values visible 3 cycles after commit.
    wr(3, 'h5A, 12, -7);
    base = done_cnt;
    commit_pulse();
    chk("ld_ready_wait", wr_ready_o, 0);
    tick();
    chk("ld_hold_t2", eps_mult_o[3], 8'd1);
    tick();
    chk("ld_mult", eps_mult_o[3], 8'h5A);
    chk("ld_shift", right_shift_o[3], 8'd12);
    chk("ld_add", add_o[3], 8'hF9);
    chk("ld_other", eps_mult_o[2], 8'd1);
    chk("ld_done_t3", commit_done_o, 1);
    tick();
    chk("ld_done_drop", commit_done_o, 0);
    tick();
    chk("ld_done_once", done_cnt - base, 1);

    // Busy stall for 10 cycles, with an ignored commit in the middle.
    wr(1, 'h11, 3, 2);
    base = done_cnt;
    busy_i = 1'b1;
    commit_pulse();
    for (int k = 0; k < 10; k++) begin
      commit_i = (k == 4);
      chk("bz_ready", wr_ready_o, 0);
      chk("bz_hold", eps_mult_o[1], 8'd1);
      tick();
    end
    commit_i = 1'b0;
    busy_i = 1'b0;
    tick();
    chk("bz_hold_b1", eps_mult_o[1], 8'd1);
    tick();
    chk("bz_mult", eps_mult_o[1], 8'h11);
    chk("bz_done", commit_done_o, 1);
    tick(); tick(); tick();
    chk("bz_done_once", done_cnt - base, 1);

    // Activation slot write together with the commit.
    wr_valid_i = 1'b1; wr_idx_i = IW'(N); wr_mult_i = 8'd3; wr_shift_i = 8'd5; wr_add_i = 8'd1;
    commit_i = 1'b1;
    tick();
    wr_valid_i = 1'b0; commit_i = 1'b0;
    tick(); tick();
    chk("sc_act_mult", act_mult_o, 8'd3);
    chk("sc_act_shift", act_shift_o, 8'd5);
    chk("sc_act_add", act_add_o, 8'd1);
    tick();

    // Out-of-range index: dropped, sticky error until the next commit.
    wr(7, 'hFF, 'hFF, 'hFF);
    chk("bi_err_set", idx_err_o, 1);
    tick();
    chk("bi_err_sticky", idx_err_o, 1);
    chk("bi_ready", wr_ready_o, 1);
    commit_pulse();
    tick();
    chk("bi_err_t2", idx_err_o, 1);
    tick();
    chk("bi_err_clr", idx_err_o, 0);
    chk("bi_done", commit_done_o, 1);
    chk("bi_act_kept", act_mult_o, 8'd3);
    tick();

    // Last write to a slot wins.
    wr(2, 'h20, 1, 1);
    wr(2, 'h21, 2, -2);
    commit_pulse();
    tick(); tick();
    chk("lw_mult", eps_mult_o[2], 8'h21);
    chk("lw_add", add_o[2], 8'hFE);
    tick();

    // Reset while a commit waits on busy: everything back to reset values, commit lost.
    wr(4, 'h44, 4, 4);
    base = done_cnt;
    busy_i = 1'b1;
    commit_pulse();
    tick(); tick();
    rst_ni = 1'b0;
    #1;
    chk("rm_ready", wr_ready_o, 1);
    chk("rm_eps3", eps_mult_o[3], 8'd1);
    chk("rm_add3", add_o[3], 8'd0);
    chk("rm_act_mult", act_mult_o, 8'd1);
    tick();
    rst_ni = 1'b1;
    busy_i = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rm_no_done", done_cnt - base, 0);
    chk("rm_eps4", eps_mult_o[4], 8'd1);

`ifdef ITA_REQUANT_READBACK_EN
    wr(0, 9, 2, 4);
    rd_en_i = 1'b1; rd_idx_i = 3'd0;
    tick();
    rd_en_i = 1'b0;
    chk("rb_mult", rd_mult_o, 8'd9);
    chk("rb_shift", rd_shift_o, 8'd2);
    chk("rb_add", rd_add_o, 8'd4);
    chk("rb_no_commit", eps_mult_o[0], 8'd1);
    tick();
    chk("rb_hold", rd_mult_o, 8'd9);
    rd_en_i = 1'b1; rd_idx_i = 3'd7;
    tick();
    rd_en_i = 1'b0;
    chk("rb_oor", rd_mult_o, 8'd0);
    chk("rb_oor_noerr", idx_err_o, 0);
    wr_valid_i = 1'b1; wr_idx_i = 3'd0; wr_mult_i = 8'h77; wr_shift_i = 8'd0; wr_add_i = 8'd0;
    rd_en_i = 1'b1; rd_idx_i = 3'd0;
    tick();
    wr_valid_i = 1'b0; rd_en_i = 1'b0;
    chk("rb_old_val", rd_mult_o, 8'd9);
    tick();
`endif

    tick();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
